// File: rtl/rob_multi_pkg.sv
// rob_multi_pkg: shared entry type and widths for the reorder buffer
package rob_multi_pkg;
  localparam int PREG_W = 7;
  localparam int PC_W = 32;
  typedef struct packed {
    logic valid;
    logic done;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [PC_W-1:0] pc;
  } rob_entry_t;
endpackage

// File: rtl/rob_multi_retire_sel.sv
// rob_retire_sel: picks the in-order run of retirable entries starting at head
// valid_i/done_i : entry flags rotated so bit 0 is the head entry
// k_o            : number of entries retiring this cycle (0..RETIRE_W)
// en_o           : per-slot retire enable, slot 0 is the oldest
module rob_retire_sel #(
  parameter int DEPTH = 16,
  parameter int RETIRE_W = 2,
  localparam int K_W = $clog2(RETIRE_W + 1)
) (
  input  logic [DEPTH-1:0]    valid_i,
  input  logic [DEPTH-1:0]    done_i,
  output logic [K_W-1:0]      k_o,
  output logic [RETIRE_W-1:0] en_o
);
  logic [DEPTH-1:0] r;
  logic run;
  always_comb begin
    r = '0;
    k_o = '0;
    run = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      run = run & valid_i[i] & done_i[i] & (i < RETIRE_W);
      r[i] = run;
    end
    for (int i = 0; i < DEPTH; i++) k_o = k_o + K_W'(r[i]);
    en_o = r[RETIRE_W-1:0];
  end
endmodule

// File: rtl/rob_multi.sv
// rob_multi: reorder buffer with multi-port completion, multi-wide in-order retire and single-cycle squash
// in : clk, reset (async, active-high), write_en/pd_new_in/pd_old_in/pc_in (allocate at tail),
//      fu_done/rob_fu (per-port completion), mispredict/mispredict_tag (squash younger than tag)
// out: ptr (tail), retired_ptr (head), count, full, empty,
//      valid_retired/preg_old/preg_new (registered retire slots, slot 0 oldest)
module rob_multi #(
  parameter int DEPTH = 16,
  parameter int NUM_FU = 3,
  parameter int RETIRE_W = 2,
  parameter int PREG_W = 7,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int K_W = $clog2(RETIRE_W + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_en,
  input  logic [PREG_W-1:0]                 pd_new_in,
  input  logic [PREG_W-1:0]                 pd_old_in,
  input  logic [31:0]                       pc_in,
  input  logic [NUM_FU-1:0]                 fu_done,
  input  logic [NUM_FU-1:0][IDX_W-1:0]      rob_fu,
  input  logic                              mispredict,
  input  logic [IDX_W-1:0]                  mispredict_tag,
  output logic [IDX_W-1:0]                  ptr,
  output logic [IDX_W-1:0]                  retired_ptr,
  output logic [IDX_W:0]                    count,
  output logic                              full,
  output logic                              empty,
  output logic [RETIRE_W-1:0]               valid_retired,
  output logic [RETIRE_W-1:0][PREG_W-1:0]   preg_old,
  output logic [RETIRE_W-1:0][PREG_W-1:0]   preg_new
);
  import rob_multi_pkg::*;
  rob_entry_t ent_q [DEPTH];
  rob_entry_t ent_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, sq, off;
  logic [IDX_W:0] count_q, count_d;
  logic [RETIRE_W-1:0] vr_q, vr_d, ren;
  logic [RETIRE_W-1:0][PREG_W-1:0] po_q, po_d, pn_q, pn_d;
  logic [DEPTH-1:0] rot_v, rot_d;
  logic [K_W-1:0] k;
  logic mp, alloc;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rot_v[i] = ent_q[head_q + IDX_W'(i)].valid;
      rot_d[i] = ent_q[head_q + IDX_W'(i)].done;
    end
  end
  rob_retire_sel #(.DEPTH(DEPTH), .RETIRE_W(RETIRE_W)) u_sel (
    .valid_i(rot_v),
    .done_i (rot_d),
    .k_o    (k),
    .en_o   (ren)
  );
  always_comb begin
    ent_d = ent_q;
    vr_d = '0;
    po_d = '0;
    pn_d = '0;
    off = '0;
    mp = mispredict && ent_q[mispredict_tag].valid;
    alloc = write_en && !full && !mp;
    // entries strictly younger than the branch, up to the pre-edge tail
    sq = mp ? tail_q - mispredict_tag - IDX_W'(1) : '0;
    for (int p = 0; p < NUM_FU; p++)
      if (fu_done[p] && ent_q[rob_fu[p]].valid) ent_d[rob_fu[p]].done = 1'b1;
    for (int i = 0; i < RETIRE_W; i++)
      if (ren[i]) begin
        vr_d[i] = 1'b1;
        po_d[i] = ent_q[head_q + IDX_W'(i)].pd_old;
        pn_d[i] = ent_q[head_q + IDX_W'(i)].pd_new;
        ent_d[head_q + IDX_W'(i)] = '0;
      end
    // squash runs after completion so same-cycle completions to squashed slots are lost
    for (int i = 0; i < DEPTH; i++) begin
      off = IDX_W'(i) - mispredict_tag - IDX_W'(1);
      if (off < sq) ent_d[i] = '0;
    end
    if (alloc)
      ent_d[tail_q] = '{valid: 1'b1, done: 1'b0, pd_new: pd_new_in, pd_old: pd_old_in, pc: pc_in};
    head_d = head_q + IDX_W'(k);
    tail_d = mp ? mispredict_tag + IDX_W'(1) : tail_q + IDX_W'(alloc);
    count_d = count_q + (IDX_W+1)'(alloc) - (IDX_W+1)'(k) - (IDX_W+1)'(sq);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      vr_q <= '0;
      po_q <= '0;
      pn_q <= '0;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      vr_q <= vr_d;
      po_q <= po_d;
      pn_q <= pn_d;
    end
  end
  assign ptr = tail_q;
  assign retired_ptr = head_q;
  assign count = count_q;
  assign full = count_q == (IDX_W+1)'(DEPTH);
  assign empty = count_q == '0;
  assign valid_retired = vr_q;
  assign preg_old = po_q;
  assign preg_new = pn_q;
endmodule
